sine_burst_ctrl: RTL and testbench
==================================

# sine_burst_ctrl

Sequencer for the sine-table PWM datapath. It generates the 8-bit phase index `theta` that drives the sine lookup and PWM comparator, at a programmable step rate. It runs the waveform for a programmed number of full sine periods, then inserts a programmable dead time with PWM disabled. Supports one-shot and repeating bursts, plus a graceful stop aligned to a period boundary.

## Interface
- `DIV_W`, 24 — width of the phase-step divider.
- `CNT_W`, 16 — width of the period and gap counters.
- `clk  in  1` — system clock (50 MHz board clock).
- `rst_n  in  1` — synchronous, active-low reset.
- `cfg_valid  in  1` — configuration write strobe.
- `cfg_ready  out  1` — configuration accepted. Equals 1 exactly when the state is IDLE.
- `cfg_div  in  DIV_W` — clocks per phase step. 0 is treated as 1.
- `cfg_cycles  in  CNT_W` — full sine periods (256 steps each) per burst.
- `cfg_gap  in  CNT_W` — dead-time length, in phase steps.
- `cfg_repeat  in  1` — 1: loop bursts until stopped. 0: single burst.
- `start  in  1` — begin burst (level sampled, IDLE only).
- `stop  in  1` — graceful stop request.
- `theta  out  8` — phase index to the sine LUT.
- `theta_stb  out  1` — 1-cycle pulse, coincident with each new `theta` value.
- `pwm_en  out  1` — PWM output enable. When 0, the datapath forces its output low.
- `busy  out  1` — state is not IDLE.
- `done  out  1` — 1-cycle pulse on every transition into IDLE.

## Operation
- **States:** IDLE, RUN, GAP.
- **Shadow registers:** `div`, `cycles`, `gap`, `repeat`.
  - Loaded on `cfg_valid && cfg_ready`.
  - Reset values: div=1, cycles=1, gap=0, repeat=0.
- **Prescaler:**
  - Counts 0..div-1 and is cleared on entry to RUN or GAP.
  - A "tick" occurs in the cycle where the prescaler equals div-1; the prescaler then wraps to 0.
- **IDLE:**
  - `start && !stop && cycles!=0` → RUN, with theta=0, period counter=0, stop_pending=0.
  - `start` with cycles==0 is ignored.
  - `stop` is ignored.
  - `start && stop` in the same cycle: stay IDLE.
- **RUN:**
  - `pwm_en`=1.
  - On each tick, theta increments mod 256. The full range 0..255 is used; 255 wraps to 0.
  - On a wrap 255→0, the period counter increments.
  - `stop` in RUN sets stop_pending. It takes effect at the next 255→0 wrap, which goes to IDLE and skips the gap.
- **End of burst:** on the wrap at which the period counter reaches `cycles`:
  - gap!=0 → GAP.
  - gap==0 and repeat=1 → restart RUN with period counter=0. There is no idle cycle and theta continues from 0.
  - gap==0 and repeat=0 → IDLE.
- **GAP:**
  - `pwm_en`=0, theta held at 0, no `theta_stb`.
  - Counts `gap` ticks. At the last tick: repeat=1 → RUN (counters cleared); otherwise → IDLE.
  - `stop` or stop_pending in GAP → IDLE on the next edge.
- **Configuration while busy:** `cfg_valid` outside IDLE is dropped; shadow registers are unchanged.
- **Reset:**
  - Values: state=IDLE, theta=0, theta_stb=0, pwm_en=0, busy=0, done=0.
  - Shadow registers return to their reset values.
  - Takes effect on the next edge regardless of state; no done pulse is generated.

## Timing
- **Start latency:** `start` sampled at edge E → busy=1, pwm_en=1, theta=0 after edge E+1.
- **Step timing:**
  - First theta step at edge E+1+div.
  - Subsequent steps every div clocks.
  - `theta_stb` is high for the one cycle following each step edge.
- **Burst length:** RUN lasts exactly cycles·256·div clocks. The final wrap edge simultaneously sets theta=0 and pwm_en=0 and changes state.
- **Gap length:** exactly gap·div clocks.
- **done:**
  - Asserted in the first IDLE cycle only.
  - busy=0 and cfg_ready=1 in that same cycle.
  - A new `start` is accepted in that cycle.
- **Stop from GAP:** `stop` at edge S → IDLE and done after edge S+1.
- All outputs are registered except `cfg_ready`, which is decoded from state.

## Test plan
- **One-shot, no gap:** div=2, cycles=1, gap=0, repeat=0; start at edge 0 → pwm_en=1 for 512 cycles; theta 0→255 stepping every 2 clocks; theta=0, pwm_en=0, done=1 after edge 513.
- **Repeat with gap:** div=1, cycles=2, gap=10, repeat=1 → repeating pattern: 512 clocks pwm_en=1, then 10 clocks pwm_en=0 with theta=0; no done pulses; 3 full loops checked.
- **Graceful stop:** div=1, cycles=5, repeat=1; stop pulsed at theta=100 in period 0 → theta continues to 255; IDLE plus done at the wrap (256 clocks after start+1); no gap inserted.
- **Config and start edge cases:**
  - cfg_valid while busy with cfg_div=7 → ignored; step period stays at the old div.
  - cfg_div=0 → step every clock.
  - cycles=0 with start → stays IDLE, busy=0.
  - start+stop together in IDLE → stays IDLE.
- **Reset mid-operation:** rst_n low for 1 cycle during RUN at theta=37 → next cycle all outputs at reset values, shadow div=1; a subsequent start with no new config gives a 256-clock burst.

Source files
------------

// File: rtl/sine_burst_ctrl.sv
// sine_burst_ctrl: phase-index sequencer for sine PWM bursts with dead time, repeat and graceful stop
module sine_burst_ctrl #(
  parameter int DIV_W = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_cycles,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic             cfg_repeat,
  input  logic             start,
  input  logic             stop,
  output logic [7:0]       theta,
  output logic             theta_stb,
  output logic             pwm_en,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;
  state_t r_state, w_nxt;
  logic [DIV_W-1:0] r_div, r_pre;
  logic [CNT_W-1:0] r_cycles, r_gap, r_per, r_gcnt;
  logic             r_repeat, r_stop_pend, r_stb, r_pwm, r_busy, r_done;
  logic [7:0]       r_theta;
  logic             w_tick, w_wrap, w_last_per, w_last_gap;
  assign w_tick     = r_pre == r_div - 1'b1;
  assign w_wrap     = w_tick && r_theta == 8'hFF;
  assign w_last_per = r_per == r_cycles - 1'b1;
  assign w_last_gap = r_gcnt == r_gap - 1'b1;
  assign cfg_ready  = r_state == S_IDLE;
  assign theta      = r_theta;
  assign theta_stb  = r_stb;
  assign pwm_en     = r_pwm;
  assign busy       = r_busy;
  assign done       = r_done;
  always_ff @(posedge clk)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: w_nxt = (start && !stop && r_cycles != '0) ? S_RUN : S_IDLE;
      S_RUN: begin
        if (w_wrap && r_stop_pend) w_nxt = S_IDLE;
        else if (w_wrap && w_last_per) w_nxt = r_gap != '0 ? S_GAP : (r_repeat ? S_RUN : S_IDLE);
      end
      S_GAP: begin
        if (stop || r_stop_pend) w_nxt = S_IDLE;
        else if (w_tick && w_last_gap) w_nxt = r_repeat ? S_RUN : S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end
  // Shadow div stores 0 as 1 so the tick compare never underflows
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div       <= DIV_W'(1);
      r_cycles    <= CNT_W'(1);
      r_gap       <= '0;
      r_repeat    <= 1'b0;
      r_pre       <= '0;
      r_theta     <= '0;
      r_per       <= '0;
      r_gcnt      <= '0;
      r_stop_pend <= 1'b0;
      r_stb       <= 1'b0;
      r_pwm       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (cfg_valid && r_state == S_IDLE) begin
        r_div    <= cfg_div == '0 ? DIV_W'(1) : cfg_div;
        r_cycles <= cfg_cycles;
        r_gap    <= cfg_gap;
        r_repeat <= cfg_repeat;
      end
      r_pre       <= (r_state == S_IDLE || w_tick) ? '0 : r_pre + 1'b1;
      r_theta     <= w_nxt != S_RUN ? '0 : (r_state == S_RUN && w_tick) ? r_theta + 1'b1 : r_theta;
      r_per       <= r_state != S_RUN ? '0 : w_wrap ? (w_last_per ? '0 : r_per + 1'b1) : r_per;
      r_gcnt      <= r_state != S_GAP ? '0 : w_tick ? r_gcnt + 1'b1 : r_gcnt;
      r_stop_pend <= r_state == S_RUN && (r_stop_pend || stop);
      r_stb       <= r_state == S_RUN && w_nxt == S_RUN && w_tick;
      r_pwm       <= w_nxt == S_RUN;
      r_busy      <= w_nxt != S_IDLE;
      r_done      <= w_nxt == S_IDLE && r_state != S_IDLE;
    end
  end
endmodule

// File: tb/tb_sine_burst_ctrl.sv
// tb_sine_burst_ctrl: directed self-checking bench for sine_burst_ctrl
module tb_sine_burst_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cfg_valid = 1'b0, cfg_ready, cfg_repeat = 1'b0, start = 1'b0, stop = 1'b0;
  logic [23:0] cfg_div = '0;
  logic [15:0] cfg_cycles = '0, cfg_gap = '0;
  logic [7:0]  theta;
  logic        theta_stb, pwm_en, busy, done;
  int          total = 0, bad = 0;
  sine_burst_ctrl #(.DIV_W(24), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_cycles(cfg_cycles), .cfg_gap(cfg_gap), .cfg_repeat(cfg_repeat),
    .start(start), .stop(stop), .theta(theta), .theta_stb(theta_stb),
    .pwm_en(pwm_en), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic tk();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cfg(input int d, input int c, input int g, input logic r);
    cfg_div = 24'(d); cfg_cycles = 16'(c); cfg_gap = 16'(g); cfg_repeat = r;
    cfg_valid = 1'b1;
    tk();
    cfg_valid = 1'b0;
  endtask
  task automatic go();
    start = 1'b1;
    tk();
    start = 1'b0;
  endtask
  initial begin
    int p;
    tk(); tk();
    chk("rst_theta", 32'(theta), 0);
    chk("rst_stb", 32'(theta_stb), 0);
    chk("rst_pwm", 32'(pwm_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    rst_n = 1'b1;
    // one-shot div=2, plus a config write while busy that must be dropped
    cfg(2, 1, 0, 1'b0);
    go();
    chk("t1_busy0", 32'(busy), 1);
    chk("t1_pwm0", 32'(pwm_en), 1);
    chk("t1_theta0", 32'(theta), 0);
    chk("t1_ready0", 32'(cfg_ready), 0);
    for (int k = 1; k <= 512; k++) begin
      if (k == 10) begin cfg_valid = 1'b1; cfg_div = 24'd7; cfg_cycles = 16'd3; end
      tk();
      cfg_valid = 1'b0;
      chk("t1_theta", 32'(theta), k < 512 ? k / 2 : 0);
      chk("t1_pwm", 32'(pwm_en), k < 512 ? 1 : 0);
      chk("t1_stb", 32'(theta_stb), (k < 512 && k % 2 == 0) ? 1 : 0);
      chk("t1_done", 32'(done), k == 512 ? 1 : 0);
    end
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_ready_end", 32'(cfg_ready), 1);
    tk();
    chk("t1_done_clr", 32'(done), 0);
    // repeating bursts with gap, then stop from GAP
    cfg(1, 2, 10, 1'b1);
    go();
    for (int t = 0; t < 3 * 522 + 516; t++) begin
      if (t > 0) tk();
      p = t % 522;
      chk("t2_theta", 32'(theta), p < 512 ? p % 256 : 0);
      chk("t2_pwm", 32'(pwm_en), p < 512 ? 1 : 0);
      chk("t2_busy", 32'(busy), 1);
      chk("t2_done", 32'(done), 0);
      if (p > 0) chk("t2_stb", 32'(theta_stb), p < 512 ? 1 : 0);
    end
    stop = 1'b1;
    tk();
    stop = 1'b0;
    chk("t2_stop_busy", 32'(busy), 0);
    chk("t2_stop_done", 32'(done), 1);
    chk("t2_stop_pwm", 32'(pwm_en), 0);
    tk();
    chk("t2_done_clr", 32'(done), 0);
    // graceful stop at theta=100 finishes the period, no gap
    cfg(1, 5, 3, 1'b1);
    go();
    for (int t = 1; t <= 256; t++) begin
      tk();
      stop = 1'b0;
      chk("t3_theta", 32'(theta), t < 256 ? t : 0);
      chk("t3_busy", 32'(busy), t < 256 ? 1 : 0);
      chk("t3_done", 32'(done), t == 256 ? 1 : 0);
      if (t == 100) stop = 1'b1;
    end
    tk();
    chk("t3_nogap", 32'(busy), 0);
    // div=0 behaves as div=1; restart accepted in the done cycle
    cfg(0, 1, 0, 1'b0);
    go();
    for (int t = 1; t <= 256; t++) begin
      tk();
      chk("t4_theta", 32'(theta), t < 256 ? t : 0);
    end
    chk("t4_done", 32'(done), 1);
    go();
    chk("t4_restart", 32'(busy), 1);
    repeat (256) tk();
    chk("t4_done2", 32'(done), 1);
    chk("t4_busy2", 32'(busy), 0);
    // cycles=0 start ignored; start+stop together ignored
    cfg(1, 0, 0, 1'b0);
    go();
    chk("t5_cyc0_busy", 32'(busy), 0);
    chk("t5_cyc0_ready", 32'(cfg_ready), 1);
    cfg(1, 1, 0, 1'b0);
    start = 1'b1; stop = 1'b1;
    tk();
    start = 1'b0; stop = 1'b0;
    chk("t6_ss_busy", 32'(busy), 0);
    tk();
    chk("t6_ss_busy2", 32'(busy), 0);
    // reset mid-run restores shadow defaults
    cfg(3, 2, 0, 1'b0);
    go();
    repeat (111) tk();
    chk("t7_theta37", 32'(theta), 37);
    rst_n = 1'b0;
    tk();
    rst_n = 1'b1;
    chk("t7_theta", 32'(theta), 0);
    chk("t7_stb", 32'(theta_stb), 0);
    chk("t7_pwm", 32'(pwm_en), 0);
    chk("t7_busy", 32'(busy), 0);
    chk("t7_done", 32'(done), 0);
    chk("t7_ready", 32'(cfg_ready), 1);
    go();
    chk("t7_run_busy", 32'(busy), 1);
    chk("t7_run_done", 32'(done), 0);
    tk();
    chk("t7_div1", 32'(theta), 1);
    repeat (254) tk();
    chk("t7_theta255", 32'(theta), 255);
    chk("t7_busy255", 32'(busy), 1);
    tk();
    chk("t7_end_done", 32'(done), 1);
    chk("t7_end_busy", 32'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
